// File: rtl/fpdiv_seq_ctrl_pkg.sv
// Shared control definitions for the Goldschmidt divider: the sequencer
// state encoding, the multiplier operand-select codes and the output
// decode used by the sequencer.
package fpdiv_ctrl_pkg;

    // Width of the refinement index. NUM_ITER is limited to 0..15.
    localparam int ITER_W = 4;

    // Multiplier operand-A select (mux4).
    localparam logic [1:0] SEL4_NUM = 2'b00;
    localparam logic [1:0] SEL4_DEN = 2'b01;
    localparam logic [1:0] SEL4_A   = 2'b10;
    localparam logic [1:0] SEL4_B   = 2'b11;

    // Multiplier operand-B select (mux3).
    localparam logic [1:0] SEL3_IA  = 2'b00;
    localparam logic [1:0] SEL3_C   = 2'b01;
    localparam logic [1:0] SEL3_REM = 2'b10;

    // Encoding 3'd7 is unused; the sequencer recovers from it to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT_A = 3'd1,
        ST_INIT_B = 3'd2,
        ST_ITER_A = 3'd3,
        ST_ITER_B = 3'd4,
        ST_REM    = 3'd5,
        ST_DONE   = 3'd6
    } fpdiv_state_t;

    // Everything the datapath sees, decoded from state alone.
    typedef struct packed {
        logic [1:0] sel_mux4;
        logic [1:0] sel_mux3;
        logic       en_a;
        logic       en_b;
        logic       en_rem;
        logic       busy;
        logic       done;
    } fpdiv_ctrl_t;

    // True in the states where the datapath is working on an operand.
    function automatic logic state_busy(input fpdiv_state_t s);
        return (s == ST_INIT_A) || (s == ST_INIT_B) || (s == ST_ITER_A) ||
               (s == ST_ITER_B) || (s == ST_REM);
    endfunction

    // Moore output table. At most one load enable is set per state.
    function automatic fpdiv_ctrl_t decode_state(input fpdiv_state_t s);
        fpdiv_ctrl_t o;
        o = '0;
        case (s)
            ST_INIT_A: begin
                o.sel_mux4 = SEL4_NUM; o.sel_mux3 = SEL3_IA;
                o.en_a = 1'b1; o.busy = 1'b1;
            end
            ST_INIT_B: begin
                o.sel_mux4 = SEL4_DEN; o.sel_mux3 = SEL3_IA;
                o.en_b = 1'b1; o.busy = 1'b1;
            end
            ST_ITER_A: begin
                o.sel_mux4 = SEL4_A; o.sel_mux3 = SEL3_C;
                o.en_a = 1'b1; o.busy = 1'b1;
            end
            ST_ITER_B: begin
                o.sel_mux4 = SEL4_B; o.sel_mux3 = SEL3_C;
                o.en_b = 1'b1; o.busy = 1'b1;
            end
            ST_REM: begin
                o.sel_mux4 = SEL4_DEN; o.sel_mux3 = SEL3_REM;
                o.en_rem = 1'b1; o.busy = 1'b1;
            end
            ST_DONE: begin
                o.done = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fpdiv_seq_ctrl_if.sv
// Control bundle between the FP unit top (master: issues start/abort,
// observes status) and the divider sequencer (slave: drives the datapath
// selects/enables and status).
interface fpdiv_seq_ctrl_if;
    import fpdiv_ctrl_pkg::*;

    logic              start;
    logic              abort;
    logic [1:0]        sel_mux4;
    logic [1:0]        sel_mux3;
    logic              en_a;
    logic              en_b;
    logic              en_rem;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter;

    modport master (
        output start, abort,
        input  sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done, iter
    );

    modport slave (
        input  start, abort,
        output sel_mux4, sel_mux3, en_a, en_b, en_rem, busy, done, iter
    );
endinterface

// File: rtl/fpdiv_seq_ctrl_iter_cnt.sv
// Refinement index counter: synchronous clear and increment, plus a
// terminal-count flag that marks the last A/B refinement pair.
module fpdiv_iter_cnt
    import fpdiv_ctrl_pkg::*;
#(
    parameter int NUM_ITER = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ITER_W-1:0] cnt,
    output logic              tc
);

    // With NUM_ITER=0 the ITER states are never entered, so the compare
    // value only needs to be something legal.
    localparam int              LAST_I = (NUM_ITER > 0) ? NUM_ITER - 1 : 0;
    localparam logic [ITER_W-1:0] LAST = LAST_I[ITER_W-1:0];

    // Counter register; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    // Terminal count: current pair is the last refinement.
    always_comb begin
        tc = (cnt == LAST);
    end

endmodule

// File: rtl/fpdiv_seq_ctrl.sv
// Goldschmidt divider sequencer. Walks the datapath through the two
// initial scalings (N*IA -> A, D*IA -> B), NUM_ITER refinement pairs and
// the remainder capture, then pulses done for one cycle. Outputs are a
// pure decode of the registered state.
module fpdiv_seq_ctrl
    import fpdiv_ctrl_pkg::*;
#(
    parameter int NUM_ITER = 6
) (
    input  logic             clk,
    input  logic             reset,
    fpdiv_seq_ctrl_if.slave  bus
);

    fpdiv_state_t      state;
    fpdiv_state_t      state_nx;
    fpdiv_ctrl_t       ctrl;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_tc;
    logic [ITER_W-1:0] iter_q;

    fpdiv_iter_cnt #(.NUM_ITER(NUM_ITER)) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (iter_q),
        .tc    (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next state and counter control. Abort is applied last so it
    // overrides every busy-state transition, including the increment.
    always_comb begin
        state_nx = ST_IDLE;
        cnt_inc  = 1'b0;
        case (state)
            ST_IDLE:   state_nx = (bus.start && !bus.abort) ? ST_INIT_A : ST_IDLE;
            ST_INIT_A: state_nx = ST_INIT_B;
            ST_INIT_B: state_nx = (NUM_ITER > 0) ? ST_ITER_A : ST_REM;
            ST_ITER_A: state_nx = ST_ITER_B;
            ST_ITER_B: begin
                if (cnt_tc) begin
                    state_nx = ST_REM;
                end else begin
                    state_nx = ST_ITER_A;
                    cnt_inc  = 1'b1;
                end
            end
            ST_REM:    state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
        if (state_busy(state) && bus.abort) begin
            state_nx = ST_IDLE;
            cnt_inc  = 1'b0;
        end
    end

    // Clearing on entry to IDLE/INIT_* means the index already reads 0
    // in those states, including right after an abort.
    always_comb begin
        cnt_clr = (state_nx == ST_IDLE) || (state_nx == ST_INIT_A) ||
                  (state_nx == ST_INIT_B);
    end

    // Moore output decode.
    always_comb begin
        ctrl = decode_state(state);
    end

    assign bus.sel_mux4 = ctrl.sel_mux4;
    assign bus.sel_mux3 = ctrl.sel_mux3;
    assign bus.en_a     = ctrl.en_a;
    assign bus.en_b     = ctrl.en_b;
    assign bus.en_rem   = ctrl.en_rem;
    assign bus.busy     = ctrl.busy;
    assign bus.done     = ctrl.done;
    assign bus.iter     = iter_q;

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// Scoreboard bench for fpdiv_seq_ctrl: two instances (NUM_ITER=6 and 0).
// Each stimulus step pushes the expected next-cycle outputs; a negedge
// monitor pops and compares, and also checks cycle invariants.
module tb_fpdiv_seq_ctrl;

    localparam int E_IDLE = 0, E_INA = 1, E_INB = 2, E_ITA = 3,
                   E_ITB  = 4, E_REM = 5, E_DONE = 6;

    typedef struct {
        int          cyc;
        int          d;
        int          tid;
        logic [12:0] vec;
        logic [12:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst6, rst0;
    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq[$];

    fpdiv_seq_ctrl_if if6();
    fpdiv_seq_ctrl_if if0();

    fpdiv_seq_ctrl #(.NUM_ITER(6)) dut6 (.clk(clk), .reset(rst6), .bus(if6.slave));
    fpdiv_seq_ctrl #(.NUM_ITER(0)) dut0 (.clk(clk), .reset(rst0), .bus(if0.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Output table: {mux4,mux3,en_a,en_b,en_rem,busy,done,iter}
    function automatic logic [12:0] exp_vec(input int s, input int it);
        logic [8:0] o;
        case (s)
            E_INA:   o = 9'b00_00_1_0_0_1_0;
            E_INB:   o = 9'b01_00_0_1_0_1_0;
            E_ITA:   o = 9'b10_01_1_0_0_1_0;
            E_ITB:   o = 9'b11_01_0_1_0_1_0;
            E_REM:   o = 9'b01_10_0_0_1_1_0;
            E_DONE:  o = 9'b00_00_0_0_0_0_1;
            default: o = 9'b00_00_0_0_0_0_0;
        endcase
        return {o, it[3:0]};
    endfunction

    function automatic logic [12:0] act_vec(input int d);
        if (d == 6)
            return {if6.sel_mux4, if6.sel_mux3, if6.en_a, if6.en_b, if6.en_rem,
                    if6.busy, if6.done, if6.iter};
        return {if0.sel_mux4, if0.sel_mux3, if0.en_a, if0.en_b, if0.en_rem,
                if0.busy, if0.done, if0.iter};
    endfunction

    // Drive one cycle of inputs on DUT d and queue what it must show next.
    task automatic step(input int d, input bit st, input bit ab, input bit rs,
                        input int es, input int ei, input int tid);
        exp_t e;
        if (d == 6) begin
            if6.start = st; if6.abort = ab; rst6 = rs;
        end else begin
            if0.start = st; if0.abort = ab; rst0 = rs;
        end
        e.cyc  = cyc_cnt + 1;
        e.d    = d;
        e.tid  = tid;
        e.vec  = exp_vec(es, ei);
        // iter is unconstrained in REM/DONE
        e.mask = (es == E_REM || es == E_DONE) ? 13'h1FF0 : 13'h1FFF;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // From the INIT_A cycle of a NUM_ITER=6 division through DONE.
    task automatic div_body6(input bit st, input int tid);
        step(6, st, 0, 1, E_INB, 0, tid);
        for (int i = 0; i < 6; i++) begin
            step(6, st, 0, 1, E_ITA, i, tid);
            step(6, st, 0, 1, E_ITB, i, tid);
        end
        step(6, st, 0, 1, E_REM, 0, tid);
        step(6, st, 0, 1, E_DONE, 0, tid);
    endtask

    task automatic chk_inv(input int d, input int num);
        logic [12:0] a;
        logic [2:0]  en;
        a  = act_vec(d);
        en = a[8:6];
        n_checks++;
        if ($isunknown(en) || $countones(en) > 1) begin
            n_fail++;
            $display("FAIL onehot0 dut%0d cycle %0d: enables %b, required at most one set", d, cyc_cnt, en);
        end
        n_checks++;
        if (a[4] === 1'b1 && a[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_busy dut%0d cycle %0d: busy %b with done, required 0", d, cyc_cnt, a[5]);
        end
        if ((a[12:11] == 2'b10 && a[8]) || (a[12:11] == 2'b11 && a[7])) begin
            n_checks++;
            if (int'(a[3:0]) > num - 1) begin
                n_fail++;
                $display("FAIL iter_bound dut%0d cycle %0d: iter %0d, required <= %0d", d, cyc_cnt, a[3:0], num - 1);
            end
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pops when due.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [12:0] a;
        if (cyc_cnt > 0) begin
            chk_inv(6, 6);
            chk_inv(0, 0);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc_cnt) begin
                e = sbq.pop_front();
                a = act_vec(e.d);
                n_checks++;
                if (e.cyc < cyc_cnt || ((a ^ e.vec) & e.mask) !== 13'd0) begin
                    n_fail++;
                    $display("FAIL T%0d dut%0d cycle %0d: got %b required %b (mask %b)",
                             e.tid, e.d, e.cyc, a, e.vec, e.mask);
                end
            end
        end
    end

    initial begin
        rst6 = 1'b0; rst0 = 1'b0;
        if6.start = 1'b0; if6.abort = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        @(posedge clk);
        #1;
        // reset state, start held during reset is ignored
        step(6, 1, 0, 0, E_IDLE, 0, 0);
        step(0, 1, 0, 0, E_IDLE, 0, 0);
        step(6, 0, 0, 1, E_IDLE, 0, 0);
        step(0, 0, 0, 1, E_IDLE, 0, 0);

        // T1 single start pulse, full trace
        step(6, 1, 0, 1, E_INA, 0, 1);
        div_body6(0, 1);
        step(6, 0, 0, 1, E_IDLE, 0, 1);
        step(6, 0, 0, 1, E_IDLE, 0, 1);

        // T2 start held: DONE ignores it, IDLE picks it up
        step(6, 1, 0, 1, E_INA, 0, 2);
        div_body6(1, 2);
        step(6, 1, 0, 1, E_IDLE, 0, 2);
        step(6, 1, 0, 1, E_INA, 0, 2);
        div_body6(1, 2);
        step(6, 1, 0, 1, E_IDLE, 0, 2);
        step(6, 1, 0, 1, E_INA, 0, 2);
        step(6, 1, 0, 1, E_INB, 0, 2);
        step(6, 1, 0, 1, E_ITA, 0, 2);
        step(6, 1, 0, 1, E_ITB, 0, 2);
        step(6, 1, 1, 1, E_IDLE, 0, 2);   // abort in ITER_B
        step(6, 1, 1, 1, E_IDLE, 0, 2);   // start+abort in IDLE: abort wins
        step(6, 0, 0, 1, E_IDLE, 0, 2);

        // T3 abort in ITER_B with iter=3, then a clean division
        step(6, 1, 0, 1, E_INA, 0, 3);
        step(6, 0, 0, 1, E_INB, 0, 3);
        step(6, 0, 0, 1, E_ITA, 0, 3);
        for (int i = 0; i < 3; i++) begin
            step(6, 0, 0, 1, E_ITB, i, 3);
            step(6, 0, 0, 1, E_ITA, i + 1, 3);
        end
        step(6, 0, 0, 1, E_ITB, 3, 3);
        step(6, 0, 1, 1, E_IDLE, 0, 3);
        step(6, 0, 0, 1, E_IDLE, 0, 3);
        step(6, 0, 1, 1, E_IDLE, 0, 3);   // abort alone in IDLE
        step(6, 1, 0, 1, E_INA, 0, 3);
        div_body6(0, 3);
        step(6, 0, 0, 1, E_IDLE, 0, 3);

        // T4 reset in ITER_A with start (and abort) held
        step(6, 1, 0, 1, E_INA, 0, 4);
        step(6, 0, 0, 1, E_INB, 0, 4);
        step(6, 0, 0, 1, E_ITA, 0, 4);
        step(6, 0, 0, 1, E_ITB, 0, 4);
        step(6, 0, 0, 1, E_ITA, 1, 4);
        step(6, 1, 0, 0, E_IDLE, 0, 4);
        step(6, 1, 1, 0, E_IDLE, 0, 4);
        step(6, 0, 0, 1, E_IDLE, 0, 4);
        step(6, 1, 0, 1, E_INA, 0, 4);
        div_body6(0, 4);
        step(6, 0, 0, 1, E_IDLE, 0, 4);

        // T5 NUM_ITER=0: INIT_A, INIT_B, REM, DONE
        step(0, 1, 0, 1, E_INA, 0, 5);
        step(0, 0, 0, 1, E_INB, 0, 5);
        step(0, 0, 0, 1, E_REM, 0, 5);
        step(0, 0, 0, 1, E_DONE, 0, 5);
        step(0, 0, 0, 1, E_IDLE, 0, 5);
        step(0, 0, 0, 1, E_IDLE, 0, 5);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
